// File: rtl/pipe_pkg.sv
// Shared types for the five-stage pipeline hazard controller.
package pipe_pkg;

  localparam int unsigned REG_AW = 3;

  typedef enum logic [2:0] {
    FWD_RF    = 3'b000,
    FWD_ALU_M = 3'b001,
    FWD_RD1_M = 3'b010,
    FWD_A_W   = 3'b011,
    FWD_B_W   = 3'b100
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } hz_state_t;

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one Execute-stage source register.
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] ra_i,
  input  logic [REG_AW-1:0] wa3m_i,
  input  logic [REG_AW-1:0] wa4m_i,
  input  logic              we_am_i,
  input  logic              we_bm_i,
  input  logic [REG_AW-1:0] wa3w_i,
  input  logic [REG_AW-1:0] wa4w_i,
  input  logic              we_aw_i,
  input  logic              we_bw_i,
  output fwd_sel_t          sel_o
);

  // Youngest producer wins: Memory before Writeback, port B before port A.
  always_comb begin
    sel_o = FWD_RF;
    if (we_bm_i && (wa4m_i == ra_i)) begin
      sel_o = FWD_RD1_M;
    end else if (we_am_i && (wa3m_i == ra_i)) begin
      sel_o = FWD_ALU_M;
    end else if (we_bw_i && (wa4w_i == ra_i)) begin
      sel_o = FWD_B_W;
    end else if (we_aw_i && (wa3w_i == ra_i)) begin
      sel_o = FWD_A_W;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: forwarding, load-use and memory-wait stalls, branch
// flushes, memory watchdog and saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic              RegWriteAE,
  input  logic              MemtoRegE,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA4M,
  input  logic              RegWriteAM,
  input  logic              RegWriteBM,
  input  logic              MemReqM,
  input  logic [REG_AW-1:0] WA3W,
  input  logic [REG_AW-1:0] WA4W,
  input  logic              RegWriteAW,
  input  logic              RegWriteBW,
  input  logic              BranchTakenE,
  input  logic              MemReady,
  output logic [2:0]        ForwardAE,
  output logic [2:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              MemErr,
  output logic [CNT_W-1:0]  StallCount
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_t          state_q;
  logic [WAIT_W-1:0]  wait_q;
  logic               err_q;
  logic [CNT_W-1:0]   stall_cnt_q;

  fwd_sel_t           fwd_a;
  fwd_sel_t           fwd_b;
  logic               lduse;
  logic               memstall;

  fwd_sel u_fwd_a (
    .ra_i    (RA1E),
    .wa3m_i  (WA3M),
    .wa4m_i  (WA4M),
    .we_am_i (RegWriteAM),
    .we_bm_i (RegWriteBM),
    .wa3w_i  (WA3W),
    .wa4w_i  (WA4W),
    .we_aw_i (RegWriteAW),
    .we_bw_i (RegWriteBW),
    .sel_o   (fwd_a)
  );

  fwd_sel u_fwd_b (
    .ra_i    (RA2E),
    .wa3m_i  (WA3M),
    .wa4m_i  (WA4M),
    .we_am_i (RegWriteAM),
    .we_bm_i (RegWriteBM),
    .wa3w_i  (WA3W),
    .wa4w_i  (WA4W),
    .we_aw_i (RegWriteAW),
    .we_bw_i (RegWriteBW),
    .sel_o   (fwd_b)
  );

  assign lduse    = MemtoRegE & RegWriteAE & ((WA3E == RA1D) | (WA3E == RA2D));
  assign memstall = MemReqM & ~MemReady;

  // Mealy stall/flush/forward decode; priority ERROR > memstall > branch > lduse.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (state_q == ERROR) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      if (memstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (BranchTakenE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lduse) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // Watchdog state machine and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wait_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (memstall) begin
            state_q <= MEM_WAIT;
            wait_q  <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (MemReady) begin
            state_q <= RUN;
            wait_q  <= '0;
          end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
            state_q <= ERROR;
            err_q   <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ERROR: begin
          err_q <= 1'b1;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
      if (StallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign MemErr     = err_q;
  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl built with a short watchdog and a
// 4-bit stall counter so timeout and saturation are reachable quickly.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic [2:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA4M, WA3W, WA4W;
  logic RegWriteAE, MemtoRegE, RegWriteAM, RegWriteBM, MemReqM;
  logic RegWriteAW, RegWriteBW, BranchTakenE, MemReady;
  logic [2:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [CW-1:0] StallCount;

  typedef struct packed {
    logic [2:0]    fa;
    logic [2:0]    fb;
    logic [3:0]    st;   // {F,D,E,M}
    logic [2:0]    fl;   // {D,E,W}
    logic          err;
    logic [CW-1:0] cnt;
  } obs_t;

  typedef struct packed {
    logic [2:0] ra1e, ra2e, wa3m, wa4m, wa3w, wa4w;
    logic       am, bm, aw, bw;
    logic [2:0] fa, fb;
  } fv_t;

  typedef struct packed {
    logic req, rdy, br;
    logic [3:0] st;
    logic [2:0] fl;
    logic       err;
    logic [4:0] cnt;
  } mv_t;

  obs_t sbq[$];
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .RegWriteAE(RegWriteAE), .MemtoRegE(MemtoRegE),
    .WA3M(WA3M), .WA4M(WA4M), .RegWriteAM(RegWriteAM), .RegWriteBM(RegWriteBM),
    .MemReqM(MemReqM), .WA3W(WA3W), .WA4W(WA4W),
    .RegWriteAW(RegWriteAW), .RegWriteBW(RegWriteBW),
    .BranchTakenE(BranchTakenE), .MemReady(MemReady),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemErr(MemErr), .StallCount(StallCount)
  );

  function automatic obs_t mk(input logic [2:0] fa, input logic [2:0] fb,
                              input logic [3:0] st, input logic [2:0] fl,
                              input logic err, input int unsigned cnt);
    obs_t o;
    o.fa = fa; o.fb = fb; o.st = st; o.fl = fl; o.err = err; o.cnt = CW'(cnt);
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.fa  = ForwardAE;
    o.fb  = ForwardBE;
    o.st  = {StallF, StallD, StallE, StallM};
    o.fl  = {FlushD, FlushE, FlushW};
    o.err = MemErr;
    o.cnt = StallCount;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("fa=%b fb=%b st=%b fl=%b err=%b cnt=%0d",
                     o.fa, o.fb, o.st, o.fl, o.err, o.cnt);
  endfunction

  task automatic idle();
    RA1D = 3'd0; RA2D = 3'd0; RA1E = 3'd0; RA2E = 3'd0; WA3E = 3'd0;
    WA3M = 3'd0; WA4M = 3'd0; WA3W = 3'd0; WA4W = 3'd0;
    RegWriteAE = 1'b0; MemtoRegE = 1'b0; RegWriteAM = 1'b0; RegWriteBM = 1'b0;
    MemReqM = 1'b0; RegWriteAW = 1'b0; RegWriteBW = 1'b0;
    BranchTakenE = 1'b0; MemReady = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_mem(input mv_t v);
    @(negedge clk);
    idle();
    MemReqM = v.req; MemReady = v.rdy; BranchTakenE = v.br;
    sbq.push_back(mk(3'b000, 3'b000, v.st, v.fl, v.err, 32'(v.cnt)));
  endtask

  task automatic test_reset();
    obs_t got, want;
    // Hazard-looking inputs while reset is high must be masked.
    @(negedge clk);
    idle();
    RA1E = 3'd3; WA3M = 3'd3; RegWriteAM = 1'b1; MemReqM = 1'b1; BranchTakenE = 1'b1;
    MemtoRegE = 1'b1; RegWriteAE = 1'b1;
    sbq.push_back(mk(3'b000, 3'b000, 4'b0000, 3'b111, 1'b0, 0));
    #2;
    got = observe(); want = sbq.pop_front(); nvec++;
    if (got !== want) begin
      nmis++; $display("FAIL reset_active: got %s want %s", fmt(got), fmt(want));
    end
    @(negedge clk);
    reset = 1'b0;
    idle();
    sbq.push_back(mk(3'b000, 3'b000, 4'b0000, 3'b000, 1'b0, 0));
    #2;
    got = observe(); want = sbq.pop_front(); nvec++;
    if (got !== want) begin
      nmis++; $display("FAIL reset_release: got %s want %s", fmt(got), fmt(want));
    end
  endtask

  task automatic test_forward();
    obs_t got, want;
    fv_t  tbl [7];
    tbl = '{
      '{3'd3, 3'd7, 3'd3, 3'd3, 3'd3, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 3'b100},
      '{3'd3, 3'd7, 3'd3, 3'd3, 3'd3, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 3'b100},
      '{3'd3, 3'd7, 3'd3, 3'd3, 3'd3, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 3'b011, 3'b100},
      '{3'd3, 3'd7, 3'd3, 3'd3, 3'd3, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000},
      '{3'd0, 3'd0, 3'd0, 3'd5, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b001, 3'b001},
      '{3'd6, 3'd6, 3'd1, 3'd1, 3'd6, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 3'b100, 3'b100},
      '{3'd2, 3'd4, 3'd4, 3'd2, 3'd2, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b011, 3'b001}
    };
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      idle();
      RA1E = tbl[i].ra1e; RA2E = tbl[i].ra2e;
      WA3M = tbl[i].wa3m; WA4M = tbl[i].wa4m; WA3W = tbl[i].wa3w; WA4W = tbl[i].wa4w;
      RegWriteAM = tbl[i].am; RegWriteBM = tbl[i].bm;
      RegWriteAW = tbl[i].aw; RegWriteBW = tbl[i].bw;
      sbq.push_back(mk(tbl[i].fa, tbl[i].fb, 4'b0000, 3'b000, 1'b0, 0));
      #2;
      got = observe(); want = sbq.pop_front(); nvec++;
      if (got !== want) begin
        nmis++; $display("FAIL forward[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_load_use();
    obs_t got, want;
    // {memtoreg, rwa, wa3e, ra1d, ra2d, br} -> {stalls, flushes, cnt}
    logic [2:0] wa3e [5] = '{3'd5, 3'd0, 3'd5, 3'd5, 3'd5};
    logic [2:0] ra1d [5] = '{3'd0, 3'd0, 3'd0, 3'd5, 3'd5};
    logic [2:0] ra2d [5] = '{3'd5, 3'd0, 3'd5, 3'd0, 3'd0};
    logic       m2r  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       rwa  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       br   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] st   [5] = '{4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [2:0] fl   [5] = '{3'b010, 3'b000, 3'b000, 3'b110, 3'b000};
    int         cnt  [5] = '{0, 1, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle();
      MemtoRegE = m2r[i]; RegWriteAE = rwa[i]; WA3E = wa3e[i];
      RA1D = ra1d[i]; RA2D = ra2d[i]; BranchTakenE = br[i];
      sbq.push_back(mk(3'b000, 3'b000, st[i], fl[i], 1'b0, 32'(cnt[i])));
      #2;
      got = observe(); want = sbq.pop_front(); nvec++;
      if (got !== want) begin
        nmis++; $display("FAIL load_use[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_mem_wait();
    obs_t got, want;
    mv_t  tbl [5];
    tbl = '{
      '{1'b1, 1'b0, 1'b0, 4'hF, 3'b001, 1'b0, 5'd0},
      '{1'b1, 1'b0, 1'b0, 4'hF, 3'b001, 1'b0, 5'd1},
      '{1'b1, 1'b0, 1'b0, 4'hF, 3'b001, 1'b0, 5'd2},
      '{1'b1, 1'b1, 1'b0, 4'h0, 3'b000, 1'b0, 5'd3},
      '{1'b0, 1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 5'd3}
    };
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_mem(tbl[i]);
      #2;
      got = observe(); want = sbq.pop_front(); nvec++;
      if (got !== want) begin
        nmis++; $display("FAIL mem_wait[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_branch_wait();
    obs_t got, want;
    mv_t  tbl [4];
    tbl = '{
      '{1'b1, 1'b0, 1'b1, 4'hF, 3'b001, 1'b0, 5'd0},
      '{1'b1, 1'b0, 1'b1, 4'hF, 3'b001, 1'b0, 5'd1},
      '{1'b1, 1'b1, 1'b1, 4'h0, 3'b110, 1'b0, 5'd2},
      '{1'b0, 1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 5'd2}
    };
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_mem(tbl[i]);
      #2;
      got = observe(); want = sbq.pop_front(); nvec++;
      if (got !== want) begin
        nmis++; $display("FAIL branch_wait[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, want;
    mv_t  tbl [9];
    // Second wait restarts at 1, so MemReady on its 5th cycle (count == TO) still wins.
    tbl = '{
      '{1'b1, 1'b0, 1'b0, 4'hF, 3'b001, 1'b0, 5'd0},
      '{1'b1, 1'b0, 1'b0, 4'hF, 3'b001, 1'b0, 5'd1},
      '{1'b1, 1'b1, 1'b0, 4'h0, 3'b000, 1'b0, 5'd2},
      '{1'b1, 1'b0, 1'b0, 4'hF, 3'b001, 1'b0, 5'd2},
      '{1'b1, 1'b0, 1'b0, 4'hF, 3'b001, 1'b0, 5'd3},
      '{1'b1, 1'b0, 1'b0, 4'hF, 3'b001, 1'b0, 5'd4},
      '{1'b1, 1'b0, 1'b0, 4'hF, 3'b001, 1'b0, 5'd5},
      '{1'b1, 1'b1, 1'b0, 4'h0, 3'b000, 1'b0, 5'd6},
      '{1'b0, 1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 5'd6}
    };
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive_mem(tbl[i]);
      #2;
      got = observe(); want = sbq.pop_front(); nvec++;
      if (got !== want) begin
        nmis++; $display("FAIL back_to_back[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_watchdog();
    obs_t got, want;
    mv_t  tbl [8];
    tbl = '{
      '{1'b1, 1'b0, 1'b0, 4'hF, 3'b001, 1'b0, 5'd0},
      '{1'b1, 1'b0, 1'b0, 4'hF, 3'b001, 1'b0, 5'd1},
      '{1'b1, 1'b0, 1'b0, 4'hF, 3'b001, 1'b0, 5'd2},
      '{1'b1, 1'b0, 1'b0, 4'hF, 3'b001, 1'b0, 5'd3},
      '{1'b1, 1'b0, 1'b0, 4'hF, 3'b001, 1'b0, 5'd4},
      '{1'b1, 1'b0, 1'b0, 4'hF, 3'b001, 1'b1, 5'd5},
      '{1'b0, 1'b1, 1'b1, 4'hF, 3'b001, 1'b1, 5'd6},
      '{1'b0, 1'b0, 1'b0, 4'hF, 3'b001, 1'b1, 5'd7}
    };
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_mem(tbl[i]);
      #2;
      got = observe(); want = sbq.pop_front(); nvec++;
      if (got !== want) begin
        nmis++; $display("FAIL watchdog[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
    do_reset();
    @(negedge clk);
    idle();
    sbq.push_back(mk(3'b000, 3'b000, 4'b0000, 3'b000, 1'b0, 0));
    #2;
    got = observe(); want = sbq.pop_front(); nvec++;
    if (got !== want) begin
      nmis++; $display("FAIL watchdog_clear: got %s want %s", fmt(got), fmt(want));
    end
  endtask

  task automatic test_saturation();
    obs_t got, want;
    do_reset();
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      idle();
      if (i < 20) begin
        MemtoRegE = 1'b1; RegWriteAE = 1'b1; WA3E = 3'd2; RA1D = 3'd2;
        sbq.push_back(mk(3'b000, 3'b000, 4'b1100, 3'b010, 1'b0, (i > 15) ? 15 : i));
      end else begin
        sbq.push_back(mk(3'b000, 3'b000, 4'b0000, 3'b000, 1'b0, 15));
      end
      #2;
      got = observe(); want = sbq.pop_front(); nvec++;
      if (got !== want) begin
        nmis++; $display("FAIL saturate[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_mem_wait();
    test_branch_wait();
    test_back_to_back();
    test_watchdog();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
